// File: rtl/bzone_dl_router_if.sv
// ioctl download stream from hps_io and ROM write port to the core.
// The master drives ioctl_* and the router (slave) drives dl_*.
interface bzone_dl_router_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wr;

  modport master (
    output ioctl_download, ioctl_wr,
    output ioctl_addr, ioctl_dout,
    output ioctl_index,
    input  dl_addr, dl_data, dl_wr
  );

  modport slave (
    input  ioctl_download, ioctl_wr,
    input  ioctl_addr, ioctl_dout,
    input  ioctl_index,
    output dl_addr, dl_data, dl_wr
  );
endinterface

// File: rtl/bzone_dl_router.sv
// Battlezone download router: ROM/core-select/DIP demux,
// ROM statistics and a stretched active-low core reset.
module bzone_dl_router #(
  parameter int          ROM_BYTES   = 32768,
  parameter int          RST_HOLD    = 1024,
  parameter logic [7:0]  MOD_DEFAULT = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ext_reset,
  bzone_dl_router_if.slave io,
  output logic [7:0]  dsw0,
  output logic [7:0]  dsw1,
  output logic        mod_battlezone,
  output logic        mod_bradley,
  output logic        mod_redbaron,
  output logic        core_reset_n,
  output logic [15:0] rom_count,
  output logic [7:0]  rom_sum,
  output logic        rom_ovf
);

  localparam int CW = $clog2(RST_HOLD + 1);

  typedef enum logic {HOLD, RUN} rst_state_t;

  rst_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          dl_prev;
  logic [7:0]    mod;
  logic          qual, idx0, in_rom;
  logic          rom_hit, start, hold_req;
  logic          dip_hit;

  assign qual     = io.ioctl_wr & io.ioctl_download;
  assign idx0     = io.ioctl_index == 8'd0;
  assign in_rom   = io.ioctl_addr < 25'(ROM_BYTES);
  assign rom_hit  = qual & idx0 & in_rom;
  assign start    = io.ioctl_download & ~dl_prev & idx0;
  assign hold_req = ext_reset | io.ioctl_download;
  assign dip_hit  = qual & (io.ioctl_index == 8'd254)
                  & (io.ioctl_addr[24:3] == 22'd0);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_prev    <= 1'b0;
      io.dl_addr <= '0;
      io.dl_data <= '0;
      io.dl_wr   <= 1'b0;
    end else begin
      dl_prev  <= io.ioctl_download;
      io.dl_wr <= rom_hit;
      if (rom_hit) begin
        io.dl_addr <= io.ioctl_addr;
        io.dl_data <= io.ioctl_dout;
      end
    end
  end

  // A download start on index 0 wins over a same-cycle ROM write.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rom_count <= '0;
      rom_sum   <= '0;
      rom_ovf   <= 1'b0;
    end else if (start) begin
      rom_count <= '0;
      rom_sum   <= '0;
      rom_ovf   <= 1'b0;
    end else if (rom_hit) begin
      if (rom_count != 16'hFFFF)
        rom_count <= rom_count + 16'd1;
      rom_sum <= rom_sum + io.ioctl_dout;
    end else if (qual & idx0) begin
      rom_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mod  <= MOD_DEFAULT;
      dsw0 <= 8'h00;
      dsw1 <= 8'h00;
    end else begin
      if (qual & (io.ioctl_index == 8'd1))
        mod <= io.ioctl_dout;
      if (dip_hit & (io.ioctl_addr[2:0] == 3'd0))
        dsw0 <= io.ioctl_dout;
      if (dip_hit & (io.ioctl_addr[2:0] == 3'd1))
        dsw1 <= io.ioctl_dout;
    end
  end

  assign mod_battlezone = mod == 8'd0;
  assign mod_bradley    = mod == 8'd1;
  assign mod_redbaron   = mod == 8'd2;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= HOLD;
      cnt   <= CW'(RST_HOLD);
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Counter reaching zero and the move to RUN share one edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    priority case (1'b1)
      hold_req: begin
        state_n = HOLD;
        cnt_n   = CW'(RST_HOLD);
      end
      (state == HOLD) && (cnt <= CW'(1)): begin
        state_n = RUN;
        cnt_n   = '0;
      end
      state == HOLD: cnt_n = cnt - CW'(1);
      default: ;
    endcase
  end

  assign core_reset_n = state == RUN;

endmodule

// File: tb/tb_bzone_dl_router.sv
// Self-checking bench for bzone_dl_router: vector table,
// randomized traffic vs. a transaction model, reset timing.
module tb_bzone_dl_router;
  localparam int ROM = 64;
  localparam int H   = 16;

  logic clk_sys = 1'b0;
  logic reset, ext_reset;
  logic [7:0] dsw0, dsw1;
  logic mod_battlezone, mod_bradley, mod_redbaron;
  logic core_reset_n, rom_ovf;
  logic [15:0] rom_count;
  logic [7:0] rom_sum;

  bzone_dl_router_if bus ();

  bzone_dl_router #(
    .ROM_BYTES(ROM), .RST_HOLD(H), .MOD_DEFAULT(8'hFF)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ext_reset(ext_reset),
    .io(bus),
    .dsw0(dsw0), .dsw1(dsw1),
    .mod_battlezone(mod_battlezone),
    .mod_bradley(mod_bradley),
    .mod_redbaron(mod_redbaron),
    .core_reset_n(core_reset_n),
    .rom_count(rom_count), .rom_sum(rom_sum),
    .rom_ovf(rom_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  int          e_mod;
  logic [15:0] e_cnt;
  logic [7:0]  e_sum, e_d0, e_d1;
  logic        e_ovf, prev_dl;

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  data;
    logic        dl;
    logic        wr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [2:0]  m;
    logic        ovf;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [2:0] mods();
    return {mod_redbaron, mod_bradley, mod_battlezone};
  endfunction

  function automatic logic [2:0] e_mods();
    return {e_mod == 2, e_mod == 1, e_mod == 0};
  endfunction

  task automatic model_reset();
    e_mod = 255; e_cnt = 0; e_sum = 0; e_ovf = 0;
    e_d0 = 0; e_d1 = 0; prev_dl = 0;
  endtask

  task automatic chk_state();
    chk("rom_count", rom_count, e_cnt);
    chk("rom_sum", rom_sum, e_sum);
    chk("rom_ovf", rom_ovf, e_ovf);
    chk("dsw0", dsw0, e_d0);
    chk("dsw1", dsw1, e_d1);
    chk("mod", mods(), e_mods());
  endtask

  task automatic chk_reset_vals();
    chk("rst dl_addr", bus.dl_addr, 0);
    chk("rst dl_data", bus.dl_data, 0);
    chk("rst dl_wr", bus.dl_wr, 0);
    chk("rst dsw0", dsw0, 0);
    chk("rst dsw1", dsw1, 0);
    chk("rst mod", mods(), 0);
    chk("rst core_reset_n", core_reset_n, 0);
    chk("rst rom_count", rom_count, 0);
    chk("rst rom_sum", rom_sum, 0);
    chk("rst rom_ovf", rom_ovf, 0);
  endtask

  // One transfer: drive, then check the 1-cycle ROM pulse.
  task automatic xfer(input logic [7:0] idx,
                      input logic [24:0] addr,
                      input logic [7:0] data,
                      input logic dl, input logic wr,
                      output logic acc);
    logic q;
    @(negedge clk_sys);
    bus.ioctl_index    = idx;
    bus.ioctl_addr     = addr;
    bus.ioctl_dout     = data;
    bus.ioctl_download = dl;
    bus.ioctl_wr       = wr;
    @(posedge clk_sys);
    q   = wr && dl;
    acc = q && idx == 0 && addr < ROM;
    if (dl && !prev_dl && idx == 0) begin
      e_cnt = 0; e_sum = 0; e_ovf = 0;
    end else if (acc) begin
      if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 1;
      e_sum = e_sum + data;
    end else if (q && idx == 0) begin
      e_ovf = 1;
    end
    if (q && idx == 1) e_mod = data;
    if (q && idx == 254 && addr == 0) e_d0 = data;
    if (q && idx == 254 && addr == 1) e_d1 = data;
    prev_dl = dl;
    #1;
    chk("dl_wr", bus.dl_wr, acc);
    if (acc) begin
      chk("dl_addr", bus.dl_addr, addr);
      chk("dl_data", bus.dl_data, data);
    end
    @(negedge clk_sys);
    bus.ioctl_wr = 0;
    @(posedge clk_sys);
    #1;
    chk("dl_wr single", bus.dl_wr, 0);
    chk_state();
  endtask

  task automatic wait_rise(string name);
    for (int i = 1; i <= H; i++) begin
      @(posedge clk_sys);
      #1;
      chk(name, core_reset_n, i >= H);
    end
  endtask

  initial begin
    logic acc;
    logic [7:0] idx;
    logic [24:0] addr;
    tbl[0]  = '{8'd0,   25'd0,  8'h10, 1, 1, 8'h00, 8'h00, 3'b000, 0};
    tbl[1]  = '{8'd0,   25'd1,  8'h20, 1, 1, 8'h00, 8'h00, 3'b000, 0};
    tbl[2]  = '{8'd0,   25'd2,  8'h30, 1, 1, 8'h00, 8'h00, 3'b000, 0};
    tbl[3]  = '{8'd0,   25'd3,  8'hF0, 1, 1, 8'h00, 8'h00, 3'b000, 0};
    tbl[4]  = '{8'd0,   25'd64, 8'hAA, 1, 0, 8'h00, 8'h00, 3'b000, 1};
    tbl[5]  = '{8'd254, 25'd0,  8'h5A, 1, 0, 8'h5A, 8'h00, 3'b000, 1};
    tbl[6]  = '{8'd254, 25'd1,  8'hC3, 1, 0, 8'h5A, 8'hC3, 3'b000, 1};
    tbl[7]  = '{8'd254, 25'd8,  8'hFF, 1, 0, 8'h5A, 8'hC3, 3'b000, 1};
    tbl[8]  = '{8'd254, 25'd0,  8'h11, 0, 0, 8'h5A, 8'hC3, 3'b000, 1};
    tbl[9]  = '{8'd1,   25'd5,  8'h02, 1, 0, 8'h5A, 8'hC3, 3'b100, 1};
    tbl[10] = '{8'd1,   25'd0,  8'h07, 1, 0, 8'h5A, 8'hC3, 3'b000, 1};
    tbl[11] = '{8'd1,   25'd9,  8'h00, 1, 0, 8'h5A, 8'hC3, 3'b001, 1};
    tbl[12] = '{8'd2,   25'd0,  8'h01, 1, 0, 8'h5A, 8'hC3, 3'b001, 1};
    tbl[13] = '{8'd254, 25'd7,  8'h33, 1, 0, 8'h5A, 8'hC3, 3'b001, 1};

    reset = 1; ext_reset = 0;
    bus.ioctl_download = 0; bus.ioctl_wr = 0;
    bus.ioctl_addr = 0; bus.ioctl_dout = 0; bus.ioctl_index = 0;
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    chk_reset_vals();
    @(negedge clk_sys);
    reset = 0;
    wait_rise("boot core_reset_n");

    xfer(8'd0, 25'd0, 8'h00, 1, 0, acc);
    foreach (tbl[i]) begin
      xfer(tbl[i].idx, tbl[i].addr, tbl[i].data,
           tbl[i].dl, 1, acc);
      chk($sformatf("vec%0d wr", i), acc, tbl[i].wr);
      chk($sformatf("vec%0d dsw0", i), dsw0, tbl[i].d0);
      chk($sformatf("vec%0d dsw1", i), dsw1, tbl[i].d1);
      chk($sformatf("vec%0d mod", i), mods(), tbl[i].m);
      chk($sformatf("vec%0d ovf", i), rom_ovf, tbl[i].ovf);
    end
    chk("tbl count", rom_count, 16'd4);
    chk("tbl sum", rom_sum, 8'h50);

    xfer(8'd0, 25'd0, 8'h00, 0, 0, acc);
    xfer(8'd0, 25'd0, 8'h00, 1, 0, acc);
    chk("restart ovf", rom_ovf, 0);
    chk("restart count", rom_count, 0);

    @(negedge clk_sys);
    bus.ioctl_download = 0;
    prev_dl = 0;
    wait_rise("dl fall core_reset_n");

    @(negedge clk_sys);
    bus.ioctl_download = 1;
    @(negedge clk_sys);
    bus.ioctl_download = 0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk_sys);
      #1;
      chk("pre ext core_reset_n", core_reset_n, 0);
    end
    @(negedge clk_sys);
    ext_reset = 1;
    @(negedge clk_sys);
    ext_reset = 0;
    wait_rise("ext core_reset_n");

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: idx = 8'd0;
        1: idx = 8'd1;
        2: idx = 8'd254;
        default: idx = 8'($urandom_range(2, 253));
      endcase
      if (idx == 8'd254) addr = 25'($urandom_range(0, 15));
      else addr = 25'($urandom_range(0, ROM + 8));
      xfer(idx, addr, 8'($urandom),
           $urandom_range(0, 9) != 0, 1, acc);
    end

    xfer(8'd0, 25'd0, 8'h00, 0, 0, acc);
    xfer(8'd0, 25'd0, 8'h00, 1, 0, acc);
    xfer(8'd0, 25'd5, 8'h77, 1, 1, acc);
    xfer(8'd1, 25'd0, 8'h01, 1, 1, acc);
    @(negedge clk_sys);
    bus.ioctl_index = 0;
    bus.ioctl_addr = 6;
    bus.ioctl_wr = 1;
    @(posedge clk_sys);
    #3;
    reset = 1;
    #1;
    chk_reset_vals();
    @(negedge clk_sys);
    reset = 0;
    bus.ioctl_wr = 0;
    bus.ioctl_download = 0;
    model_reset();
    wait_rise("post rst core_reset_n");
    chk_state();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
